// File: rtl/multicycle_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB state machine with a memory watchdog.
// Define MULTICYCLE_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       memtoreg,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic [2:0] aluop,
    output logic       busy,
    output logic       halted,
    output logic       err
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERR} state_e;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_JMP  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    localparam int              WD_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

    state_e          state_r, state_s;
    logic [3:0]      op_r, op_s;
    logic [WD_W-1:0] wait_r, wait_s;
    logic            timeout_s;

    logic       mem_req_s, mem_we_s, iord_s, reg_dst_s, memtoreg_s, alusrc_a_s;
    logic [1:0] pc_src_s, alusrc_b_s;
    logic [2:0] aluop_s;
    logic       busy_s, halted_s, err_s;
    logic       pc_write_exec_s, pc_write_cond_s, reg_write_s;
    logic       pc_write_exec_r, pc_write_cond_r, reg_write_r;

    // The zero flag is consumed by the datapath through pc_write_cond, not by the sequencer.
    logic unused_zero_s;
    assign unused_zero_s = zero;

    assign timeout_s = (MEM_TIMEOUT != 0) && (wait_r == WD_LAST);

    // Next state, opcode latch and watchdog count; the count is zero outside outstanding waits
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        wait_s  = '0;
        case (state_r)
            IDLE, HALTED: begin
                if (run) state_s = FETCH;
                else     state_s = state_r;
            end
            FETCH, MEM: begin
                if (mem_ready) begin
                    if (state_r == FETCH)    state_s = DECODE;
                    else if (op_r == OP_LW)  state_s = WB;
                    else                     state_s = FETCH;
                end else if (timeout_s) begin
                    state_s = ERR;
                end else begin
                    wait_s = wait_r + WD_W'(1);
                end
            end
            DECODE: begin
                op_s = opcode;
                if (opcode == OP_HALT) state_s = HALTED;
                else                   state_s = EXEC;
            end
            EXEC: begin
                case (op_r)
                    OP_R, OP_ADDI: state_s = WB;
                    OP_LW, OP_SW:  state_s = MEM;
                    default:       state_s = FETCH;
                endcase
            end
            WB:      state_s = FETCH;
            ERR:     state_s = ERR;
            default: state_s = IDLE;
        endcase
    end

    // Moore output decode of the state being entered, so the outputs can be registered
    always_comb begin
        mem_req_s       = 1'b0;
        mem_we_s        = 1'b0;
        iord_s          = 1'b0;
        pc_src_s        = 2'b00;
        reg_dst_s       = 1'b0;
        memtoreg_s      = 1'b0;
        alusrc_a_s      = 1'b0;
        alusrc_b_s      = 2'b00;
        aluop_s         = 3'b000;
        busy_s          = 1'b0;
        halted_s        = 1'b0;
        err_s           = 1'b0;
        pc_write_exec_s = 1'b0;
        pc_write_cond_s = 1'b0;
        reg_write_s     = 1'b0;
        case (state_s)
            FETCH: begin
                mem_req_s  = 1'b1;
                alusrc_b_s = 2'b01;
                busy_s     = 1'b1;
            end
            DECODE: begin
                alusrc_b_s = 2'b10;
                busy_s     = 1'b1;
            end
            EXEC: begin
                busy_s = 1'b1;
                case (op_s)
                    OP_R: begin
                        alusrc_a_s = 1'b1;
                        aluop_s    = 3'b010;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alusrc_a_s = 1'b1;
                        alusrc_b_s = 2'b10;
                    end
                    OP_BEQ: begin
                        alusrc_a_s      = 1'b1;
                        aluop_s         = 3'b001;
                        pc_write_cond_s = 1'b1;
                        pc_src_s        = 2'b01;
                    end
                    OP_JMP: begin
                        pc_write_exec_s = 1'b1;
                        pc_src_s        = 2'b10;
                    end
                    default: busy_s = 1'b1;
                endcase
            end
            MEM: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                mem_we_s  = (op_s == OP_SW);
                busy_s    = 1'b1;
            end
            WB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = (op_s == OP_R);
                memtoreg_s  = (op_s == OP_LW);
                busy_s      = 1'b1;
            end
            HALTED:  halted_s = 1'b1;
            ERR: begin
                halted_s = 1'b1;
                err_s    = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Sequencer state, latched opcode, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            op_r            <= 4'd0;
            wait_r          <= '0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            iord            <= 1'b0;
            pc_src          <= 2'b00;
            reg_dst         <= 1'b0;
            memtoreg        <= 1'b0;
            alusrc_a        <= 1'b0;
            alusrc_b        <= 2'b00;
            aluop           <= 3'b000;
            busy            <= 1'b0;
            halted          <= 1'b0;
            err             <= 1'b0;
            pc_write_exec_r <= 1'b0;
            pc_write_cond_r <= 1'b0;
            reg_write_r     <= 1'b0;
        end else begin
            state_r         <= state_s;
            op_r            <= op_s;
            wait_r          <= wait_s;
            mem_req         <= mem_req_s;
            mem_we          <= mem_we_s;
            iord            <= iord_s;
            pc_src          <= pc_src_s;
            reg_dst         <= reg_dst_s;
            memtoreg        <= memtoreg_s;
            alusrc_a        <= alusrc_a_s;
            alusrc_b        <= alusrc_b_s;
            aluop           <= aluop_s;
            busy            <= busy_s;
            halted          <= halted_s;
            err             <= err_s;
            pc_write_exec_r <= pc_write_exec_s;
            pc_write_cond_r <= pc_write_cond_s;
            reg_write_r     <= reg_write_s;
        end
    end

    // IR/PC load must coincide with the mem_ready cycle; all strobes are suppressed while rst is high.
    assign ir_write      = (state_r == FETCH) && mem_ready && !rst;
    assign pc_write      = (ir_write || pc_write_exec_r) && !rst;
    assign pc_write_cond = pc_write_cond_r && !rst;
    assign reg_write     = reg_write_r && !rst;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic instr_done_s;

    assign instr_done_s = ((state_s == FETCH) && ((state_r == EXEC) || (state_r == MEM) || (state_r == WB)))
                       || ((state_r == DECODE) && (state_s == HALTED));

    // Busy-cycle and retired-instruction counters, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy) cycle_cnt <= cycle_cnt + CNT_W'(1);
            else      cycle_cnt <= cycle_cnt;
            if (instr_done_s) instr_cnt <= instr_cnt + CNT_W'(1);
            else              instr_cnt <= instr_cnt;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer against a per-instruction phase model.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst, run, zero, mem_ready;
    logic [3:0] opcode;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alusrc_b;
    logic       reg_write, reg_dst, memtoreg, alusrc_a;
    logic [2:0] aluop;
    logic       busy, halted, err;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .memtoreg(memtoreg), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluop(aluop),
        .busy(busy), .halted(halted), .err(err)
`ifdef MULTICYCLE_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src, reg_write,
                       reg_dst, memtoreg, alusrc_a, alusrc_b, aluop, busy, halted, err};

    typedef struct { bit run; bit rdy; bit [3:0] opc; bit [19:0] exp; } cyc_t;
    cyc_t      sq[$];
    bit [19:0] obs_q[$];
    bit [19:0] rest_v;
    int        n_tests = 0;
    int        n_fail  = 0;

    function automatic bit [19:0] mk(bit req, bit we, bit io, bit irw, bit pcw, bit pwc, bit [1:0] src,
                                     bit rw, bit rd, bit m2r, bit a, bit [1:0] b, bit [2:0] op,
                                     bit bsy, bit hlt, bit er);
        return {req, we, io, irw, pcw, pwc, src, rw, rd, m2r, a, b, op, bsy, hlt, er};
    endfunction

    // Expected outputs of each phase, straight from the control table
    function automatic bit [19:0] v_fetch(bit rdy);
        return mk(1, 0, 0, rdy, rdy, 0, 2'b00, 0, 0, 0, 0, 2'b01, 3'b000, 1, 0, 0);
    endfunction
    function automatic bit [19:0] v_dec();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 3'b000, 1, 0, 0);
    endfunction
    function automatic bit [19:0] v_exec(bit [3:0] op);
        case (op)
            4'd0:             return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b010, 1, 0, 0);
            4'd1, 4'd2, 4'd3: return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 3'b000, 1, 0, 0);
            4'd4:             return mk(0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 2'b00, 3'b001, 1, 0, 0);
            4'd5:             return mk(0, 0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0, 0);
            default:          return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0, 0);
        endcase
    endfunction
    function automatic bit [19:0] v_mem(bit sw);
        return mk(1, sw, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0, 0);
    endfunction
    function automatic bit [19:0] v_wb(bit rd, bit m2r);
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 1, rd, m2r, 0, 2'b00, 3'b000, 1, 0, 0);
    endfunction
    function automatic bit [19:0] v_halted();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 0);
    endfunction
    function automatic bit [19:0] v_err();
        return mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 1);
    endfunction

    // FETCH-to-FETCH latency with zero-wait memory (HALT: FETCH to HALTED)
    function automatic int lat(bit [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd3: return 4;
            4'd2:             return 5;
            4'd6:             return 2;
            default:          return 3;
        endcase
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction
    function automatic bit [3:0] rn();
        return 4'($urandom_range(15, 0));
    endfunction

    function automatic void add(bit r, bit rdy, bit [3:0] opc, bit [19:0] e);
        cyc_t c;
        c.run = r; c.rdy = rdy; c.opc = opc; c.exp = e;
        sq.push_back(c);
    endfunction

    // One instruction: fd/md = mem_ready wait cycles in FETCH/MEM; run and off-phase inputs are noise
    function automatic void model_instr(bit [3:0] op, int fd, int md);
        for (int i = 0; i < fd; i++) add(rb(), 1'b0, rn(), v_fetch(1'b0));
        add(rb(), 1'b1, rn(), v_fetch(1'b1));
        add(rb(), rb(), op, v_dec());
        if (op == 4'd6) return;
        add(rb(), rb(), rn(), v_exec(op));
        if (op == 4'd2 || op == 4'd3) begin
            for (int i = 0; i < md; i++) add(rb(), 1'b0, rn(), v_mem(op == 4'd3));
            add(rb(), 1'b1, rn(), v_mem(op == 4'd3));
        end
        if (op <= 4'd2) add(rb(), rb(), rn(), v_wb(op == 4'd0, op == 4'd2));
    endfunction

    function automatic void model_start();
        sq.delete();
        add(1'b1, rb(), rn(), rest_v);
    endfunction

    function automatic void model_halt();
        model_instr(4'd6, 0, 0);
        add(1'b0, rb(), rn(), v_halted());
        rest_v = v_halted();
    endfunction

    // Apply the schedule one cycle per entry, recording outputs at the falling edge
    task automatic drive();
        obs_q.delete();
        foreach (sq[i]) begin
            run = sq[i].run; mem_ready = sq[i].rdy; opcode = sq[i].opc; zero = rb();
            @(negedge clk);
            obs_q.push_back(obs);
            @(posedge clk); #1;
        end
        run = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 4'd0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 20'd0) begin n_fail++; $display("FAIL reset_state: got %b want 0", obs); end
`ifdef MULTICYCLE_PERF_CNT_EN
        n_tests++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
        end
`endif
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0; rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({mem_req, busy, ir_write, pc_write} !== 4'b1100) begin
            n_fail++; $display("FAIL rst_no_strobe: got %b want 1100", {mem_req, busy, ir_write, pc_write});
        end
        @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 20'd0) begin n_fail++; $display("FAIL rst_abort: got %b want 0", obs); end
        @(posedge clk); #1;
        rest_v = 20'd0;
    endtask

    task automatic test_rtype();
        model_start(); model_instr(4'd0, 0, 0); model_halt();
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL rtype c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
    endtask

    task automatic test_lw_wait();
        model_start(); model_instr(4'd2, 0, 3); model_instr(4'd2, 2, 1); model_halt();
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL lw_wait c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
    endtask

    task automatic test_beq();
        model_start(); model_instr(4'd4, 0, 0); model_instr(4'd4, 1, 0); model_instr(4'd5, 0, 0); model_halt();
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL beq_jmp c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
    endtask

    task automatic test_halt();
        model_start(); model_halt();
        for (int i = 0; i < 3; i++) add(1'b0, rb(), rn(), v_halted());
        add(1'b1, rb(), rn(), v_halted());
        model_instr(4'd3, 0, 0); model_instr(4'd7, 0, 0); model_halt();
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL halt c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
    endtask

    task automatic test_random();
        bit [3:0] op;
        model_start();
        for (int k = 0; k < 30; k++) begin
            op = rn();
            if (op == 4'd6) op = 4'd9;
            model_instr(op, $urandom_range(3, 0), $urandom_range(3, 0));
        end
        model_halt();
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL random c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
    endtask

    task automatic test_timeout();
        model_start();
        for (int i = 0; i < 4; i++) add(rb(), 1'b0, rn(), v_fetch(1'b0));
        for (int i = 0; i < 3; i++) add(1'b1, rb(), rn(), v_err());
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL fetch_timeout c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== 20'd0) begin n_fail++; $display("FAIL err_clear: got %b want 0", obs); end
        @(posedge clk); #1;
        rest_v = 20'd0;
        model_start();
        add(rb(), 1'b1, rn(), v_fetch(1'b1));
        add(rb(), rb(), 4'd3, v_dec());
        add(rb(), rb(), rn(), v_exec(4'd3));
        for (int i = 0; i < 4; i++) add(rb(), 1'b0, rn(), v_mem(1'b1));
        add(1'b1, rb(), rn(), v_err());
        drive();
        foreach (sq[i]) begin
            n_tests++;
            if (obs_q[i] !== sq[i].exp) begin n_fail++; $display("FAIL mem_timeout c%0d: got %b want %b", i, obs_q[i], sq[i].exp); end
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rest_v = 20'd0;
    endtask

`ifdef MULTICYCLE_PERF_CNT_EN
    task automatic test_perf();
        bit [3:0] prog[4] = '{4'd1, 4'd3, 4'd5, 4'd6};
        int exp_cyc = 0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rest_v = 20'd0;
        model_start();
        foreach (prog[k]) begin
            exp_cyc += lat(prog[k]);
            if (prog[k] == 4'd6) model_halt();
            else model_instr(prog[k], 0, 0);
        end
        drive();
        @(negedge clk);
        n_tests++;
        if (instr_cnt !== 32'd4 || cycle_cnt !== 32'(exp_cyc)) begin
            n_fail++; $display("FAIL perf_cnt: got %0d/%0d want 4/%0d", instr_cnt, cycle_cnt, exp_cyc);
        end
        @(posedge clk); #1;
        model_start();
        add(rb(), 1'b1, rn(), v_fetch(1'b1));
        add(rb(), rb(), 4'd3, v_dec());
        add(rb(), rb(), rn(), v_exec(4'd3));
        drive();
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0 || obs !== 20'd0) begin
            n_fail++; $display("FAIL perf_rst: got %0d/%0d/%b want 0/0/0", instr_cnt, cycle_cnt, obs);
        end
        @(posedge clk); #1;
        rest_v = 20'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_halt();
        test_random();
        test_timeout();
`ifdef MULTICYCLE_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
